arm_dmem_responder: RTL and testbench
=====================================

# arm_dmem_responder

Data-memory responder for the `arm_core` load/store port. It accepts one request at a time over a valid/ready handshake and applies a fixed number of wait states. It then performs a byte-, halfword- or word-sized read or write on an internal word array and returns one response with data and an exception code. It is the memory-side counterpart to the core's data-access initiator. It lets the core be exercised against realistic multi-cycle memory latency.

## Interface
- `ADDR_WIDTH`, default 32: request address width.
- `MEM_WORDS`, default 1024: depth of the 32-bit word array (power of two).
- `WAIT_CYCLES`, default 2: wait states between acceptance and access (0 allowed).

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, 1: a request is present.
- `req_ready`, output, 1: the responder can accept a request.
- `req_addr`, input, ADDR_WIDTH: byte address.
- `req_write`, input, 1: 1 = store, 0 = load.
- `req_size`, input, 2: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `req_wdata`, input, 32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `resp_valid`, output, 1: one-cycle response strobe.
- `resp_rdata`, output, 32: load data, zero-extended and right-aligned.
- `resp_excpt`, output, 2: 00 = ok, 01 = misaligned, 10 = out of range, 11 = illegal size.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - `req_ready` = 1.
  - Handshake when `req_valid & req_ready`. On handshake, latch addr/write/size/wdata and evaluate the exception.
- Exception priority: illegal size, then misaligned, then out of range.
  - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - Out of range: word index addr[ADDR_WIDTH-1:2] ≥ MEM_WORDS.
- Request with an exception: go directly to RESP with the exception code. No memory access occurs.
- Legal request: if WAIT_CYCLES = 0, go to RESP. Otherwise load the counter with WAIT_CYCLES-1 and go to BUSY.
- BUSY: decrement the counter each cycle. When it reaches 0, go to RESP.
- Memory access happens on the edge that enters RESP:
  - Write: update only the addressed byte lanes. Byte lane = addr[1:0]; halfword lanes = addr[1] ? [31:16] : [15:0].
  - Read: register the selected lanes into `resp_rdata`, zero-extended.
- RESP: `resp_valid` = 1 for exactly one cycle, then return to IDLE.
- `resp_rdata` = 0 for writes and for exceptions. `resp_excpt` = 00 on success.
- Response side has no backpressure. The consumer must take the response in the strobe cycle.
- Memory contents are not reset and are initialised only by the bench.

## Timing
- Reset: state IDLE, counter 0, `resp_valid` = 0, `resp_rdata` = 0, `resp_excpt` = 00. `req_ready` = 0 while `rst` is high and 1 in the first cycle after release.
- Handshake at edge k: `req_ready` = 0 from k until return to IDLE.
- Legal request: `resp_valid` is high in the cycle following edge k+1+WAIT_CYCLES. The write is visible to any later read.
- Exception: `resp_valid` is high in the cycle following edge k+1.
- Earliest next acceptance is the edge ending the RESP cycle. Sustained throughput is one request per WAIT_CYCLES+2 cycles.
- `req_*` inputs are ignored outside IDLE. Changes to them after the handshake have no effect.
- `rst` asserted in BUSY: abort with no write and no response. Asserted in RESP: `resp_valid` drops at that edge.
- `resp_*` outputs are registered. `req_ready` is decoded from the state register only.

## Test plan
- Word write/read, WAIT_CYCLES = 2. Stimulus: store 0xDEADBEEF to 0x10, then load 0x10. Required: `resp_valid` exactly 3 cycles after each handshake edge, load returns 0xDEADBEEF with excpt 00, and the store response has rdata 0.
- Sub-word access. Stimulus: store byte 0xAA to 0x13, then load word 0x10. Required: 0xAAADBEEF. Then load halfword 0x12. Required: 0x0000AAAD.
- Misaligned and illegal requests. Stimulus: word load at 0x11. Required: excpt 01, response 1 cycle after acceptance, no access. Stimulus: size 11. Required: excpt 11. Stimulus: word store at MEM_WORDS*4. Required: excpt 10, and a later read of word 0 is unchanged.
- Handshake discipline. Stimulus: hold `req_valid` high with changing addresses during BUSY. Required: only the first request is served, and the next is accepted at the end of the RESP cycle.
- Reset mid-operation. Stimulus: store 0x12345678 to 0x20, assert `rst` in BUSY, then load 0x20 after release. Required: the store produces no response, the old value is returned, and the FSM is back in IDLE with `req_ready` = 1.
- WAIT_CYCLES = 0 build. Stimulus: back-to-back loads. Required: response 1 cycle after each handshake, with a new acceptance every 2 cycles.

Source files
------------

// File: rtl/arm_dmem_responder.sv
// Data-memory responder for the core load/store port.
// Serves one request at a time after a fixed number of wait states. It performs a
// byte, halfword or word access on a byte-lane-split word array. It returns one
// registered response carrying the load data and an exception code.
module arm_dmem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic [1:0]            resp_excpt
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] EX_OK   = 2'b00;
    localparam logic [1:0] EX_MIS  = 2'b01;
    localparam logic [1:0] EX_OOR  = 2'b10;
    localparam logic [1:0] EX_SIZE = 2'b11;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    // State and latched request
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_lo;
    logic             r_write;
    logic [1:0]       r_size;
    logic [31:0]      r_wdata;
    logic [1:0]       r_excpt;

    // Registered response
    logic             r_resp_valid;
    logic [31:0]      r_resp_rdata;
    logic [1:0]       r_resp_excpt;

    logic             w_hs;
    logic             w_oor;
    logic [1:0]       w_req_excpt;
    logic             w_acc_go;
    logic [IDX_W-1:0] w_acc_idx;
    logic [1:0]       w_acc_lo;
    logic [1:0]       w_acc_size;
    logic             w_acc_write;
    logic [31:0]      w_acc_wdata;
    logic [3:0]       w_be;
    logic [31:0]      w_lane_wdata;
    logic [31:0]      w_rd_word;
    logic [31:0]      w_rsp_rdata;

    // Ready is derived from the state only, and forced low while reset is held
    assign req_ready  = (r_state == S_IDLE) & ~rst;
    assign w_hs       = req_valid & req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_excpt = r_resp_excpt;

    // Out of range: with a power-of-two depth, any set bit above the word index overflows
    generate
        if (ADDR_WIDTH > IDX_W + 2) begin : g_oor
            assign w_oor = |req_addr[ADDR_WIDTH-1:IDX_W+2];
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate

    // Exception for the presented request: size beats alignment beats range
    always_comb begin
        w_req_excpt = EX_OK;
        if (req_size == 2'b11) begin
            w_req_excpt = EX_SIZE;
        end else if ((req_size == SZ_H && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00)) begin
            w_req_excpt = EX_MIS;
        end else if (w_oor) begin
            w_req_excpt = EX_OOR;
        end
    end

    // Access fires on the edge entering RESP. With zero wait states that is the
    // handshake edge itself, so the live request is used instead of the latched copy.
    always_comb begin
        w_acc_go = ~rst &
                   (((r_state == S_IDLE) && w_hs && (w_req_excpt == EX_OK) && (WAIT_CYCLES == 0)) ||
                    ((r_state == S_BUSY) && (r_cnt == '0)));
        if (r_state == S_IDLE) begin
            w_acc_idx   = req_addr[IDX_W+1:2];
            w_acc_lo    = req_addr[1:0];
            w_acc_size  = req_size;
            w_acc_write = req_write;
            w_acc_wdata = req_wdata;
        end else begin
            w_acc_idx   = r_idx;
            w_acc_lo    = r_lo;
            w_acc_size  = r_size;
            w_acc_write = r_write;
            w_acc_wdata = r_wdata;
        end
    end

    // Byte-lane enables and lane-replicated store data
    always_comb begin
        w_be         = 4'b1111;
        w_lane_wdata = w_acc_wdata;
        case (w_acc_size)
            SZ_B: begin
                w_be         = 4'b0001 << w_acc_lo;
                w_lane_wdata = {4{w_acc_wdata[7:0]}};
            end
            SZ_H: begin
                w_be         = w_acc_lo[1] ? 4'b1100 : 4'b0011;
                w_lane_wdata = {2{w_acc_wdata[15:0]}};
            end
            default: begin
                w_be         = 4'b1111;
                w_lane_wdata = w_acc_wdata;
            end
        endcase
    end

    // One byte-wide array per lane so each lane has its own write enable
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [MEM_WORDS];
            logic [7:0] r_rd_byte;

            // Lane write plus registered read of the addressed word
            always_ff @(posedge clk) begin
                if (w_acc_go) begin
                    if (w_acc_write && w_be[gi]) begin
                        r_mem[w_acc_idx] <= w_lane_wdata[8*gi +: 8];
                    end
                    r_rd_byte <= r_mem[w_acc_idx];
                end
            end

            assign w_rd_word[8*gi +: 8] = r_rd_byte;
        end
    endgenerate

    // Lane selection and zero extension of load data during the RESP cycle
    always_comb begin
        w_rsp_rdata = 32'h0;
        if (r_excpt == EX_OK && !r_write) begin
            case (r_size)
                SZ_B: begin
                    case (r_lo)
                        2'd0:    w_rsp_rdata = {24'h0, w_rd_word[7:0]};
                        2'd1:    w_rsp_rdata = {24'h0, w_rd_word[15:8]};
                        2'd2:    w_rsp_rdata = {24'h0, w_rd_word[23:16]};
                        default: w_rsp_rdata = {24'h0, w_rd_word[31:24]};
                    endcase
                end
                SZ_H:    w_rsp_rdata = {16'h0, r_lo[1] ? w_rd_word[31:16] : w_rd_word[15:0]};
                default: w_rsp_rdata = w_rd_word;
            endcase
        end
    end

    // Request FSM, wait-state counter and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_excpt <= EX_OK;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_excpt <= EX_OK;
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_idx   <= req_addr[IDX_W+1:2];
                        r_lo    <= req_addr[1:0];
                        r_write <= req_write;
                        r_size  <= req_size;
                        r_wdata <= req_wdata;
                        r_excpt <= w_req_excpt;
                        if (w_req_excpt != EX_OK || WAIT_CYCLES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_cnt   <= CNT_LOAD;
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_rsp_rdata;
                    r_resp_excpt <= r_excpt;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_dmem_responder.sv
// Directed bench for arm_dmem_responder: one instance with two wait states and one
// with none, sharing the request inputs; each test observes one instance.
module tb_arm_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic [31:0] req_wdata = 32'h0;

    logic        rdy0, v0, rdy1, v1;
    logic [31:0] rd0, rd1;
    logic [1:0]  ex0, ex1;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arm_dmem_responder #(.ADDR_WIDTH(32), .MEM_WORDS(1024), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(rdy0), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(v0), .resp_rdata(rd0), .resp_excpt(ex0)
    );

    arm_dmem_responder #(.ADDR_WIDTH(32), .MEM_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(rdy1), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(v1), .resp_rdata(rd1), .resp_excpt(ex1)
    );

    // One request on the selected instance; returns edges from handshake to response
    task automatic send(input bit sel, input logic [31:0] a, input logic w, input logic [1:0] s,
                        input logic [31:0] d, output int lat, output logic [31:0] rd, output logic [1:0] ex);
        int n;
        int k;
        lat = -1;
        rd  = 32'hxxxxxxxx;
        ex  = 2'bxx;
        @(negedge clk);
        req_addr = a; req_write = w; req_size = s; req_wdata = d; req_valid = 1'b1;
        n = 0;
        while (!(sel ? rdy1 : rdy0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        k = cyc;
        req_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (sel ? v1 : v0) begin
                lat = cyc - k;
                rd  = sel ? rd1 : rd0;
                ex  = sel ? ex1 : ex0;
                break;
            end
        end
        $display("txn dut=%0d addr=%h wr=%0d size=%0d wdata=%h -> lat=%0d rdata=%h excpt=%0d",
                 sel ? 0 : 2, a, w, s, d, lat, rd, ex);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b expected 0", rdy0); end
        n_cmp++; if (v0 !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", v0); end
        n_cmp++; if (rd0 !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h expected 0", rd0); end
        n_cmp++; if (ex0 !== 2'b00) begin n_bad++; $display("FAIL rst_excpt: got %b expected 00", ex0); end
        n_cmp++; if (rdy1 !== 1'b0) begin n_bad++; $display("FAIL rst_ready_w0: got %b expected 0", rdy1); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b expected 1", rdy0); end
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic [1:0] ex;
        send(0, 32'h10, 1'b1, 2'b10, 32'hDEADBEEF, lat, rd, ex);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wst_lat: got %0d expected 3", lat); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL wst_rdata: got %h expected 0", rd); end
        n_cmp++; if (ex !== 2'b00) begin n_bad++; $display("FAIL wst_excpt: got %b expected 00", ex); end
        send(0, 32'h10, 1'b0, 2'b10, 32'h0, lat, rd, ex);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wld_lat: got %0d expected 3", lat); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wld_rdata: got %h expected deadbeef", rd); end
        n_cmp++; if (ex !== 2'b00) begin n_bad++; $display("FAIL wld_excpt: got %b expected 00", ex); end
    endtask

    task automatic test_subword();
        int lat; logic [31:0] rd; logic [1:0] ex;
        send(0, 32'h13, 1'b1, 2'b00, 32'hFFFFFFAA, lat, rd, ex);
        n_cmp++; if (ex !== 2'b00) begin n_bad++; $display("FAIL bst_excpt: got %b expected 00", ex); end
        send(0, 32'h10, 1'b0, 2'b10, 32'h0, lat, rd, ex);
        n_cmp++; if (rd !== 32'hAAADBEEF) begin n_bad++; $display("FAIL bst_word: got %h expected aaadbeef", rd); end
        send(0, 32'h12, 1'b0, 2'b01, 32'h0, lat, rd, ex);
        n_cmp++; if (rd !== 32'h0000AAAD) begin n_bad++; $display("FAIL hld_hi: got %h expected 0000aaad", rd); end
        send(0, 32'h10, 1'b0, 2'b01, 32'h0, lat, rd, ex);
        n_cmp++; if (rd !== 32'h0000BEEF) begin n_bad++; $display("FAIL hld_lo: got %h expected 0000beef", rd); end
        send(0, 32'h11, 1'b0, 2'b00, 32'h0, lat, rd, ex);
        n_cmp++; if (rd !== 32'h000000BE) begin n_bad++; $display("FAIL bld_1: got %h expected 000000be", rd); end
        send(0, 32'h18, 1'b1, 2'b01, 32'hFFFF1234, lat, rd, ex);
        send(0, 32'h1A, 1'b1, 2'b01, 32'h00005678, lat, rd, ex);
        send(0, 32'h18, 1'b0, 2'b10, 32'h0, lat, rd, ex);
        n_cmp++; if (rd !== 32'h56781234) begin n_bad++; $display("FAIL hst_word: got %h expected 56781234", rd); end
    endtask

    task automatic test_exceptions();
        int lat; logic [31:0] rd; logic [1:0] ex;
        send(0, 32'h11, 1'b0, 2'b10, 32'h0, lat, rd, ex);
        n_cmp++; if (ex !== 2'b01) begin n_bad++; $display("FAIL mis_excpt: got %b expected 01", ex); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL mis_lat: got %0d expected 1", lat); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mis_rdata: got %h expected 0", rd); end
        send(0, 32'h11, 1'b1, 2'b01, 32'h00007777, lat, rd, ex);
        n_cmp++; if (ex !== 2'b01) begin n_bad++; $display("FAIL mis_h_excpt: got %b expected 01", ex); end
        send(0, 32'h10, 1'b0, 2'b10, 32'h0, lat, rd, ex);
        n_cmp++; if (rd !== 32'hAAADBEEF) begin n_bad++; $display("FAIL mis_noacc: got %h expected aaadbeef", rd); end
        send(0, 32'h10, 1'b1, 2'b11, 32'h0, lat, rd, ex);
        n_cmp++; if (ex !== 2'b11) begin n_bad++; $display("FAIL size_excpt: got %b expected 11", ex); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL size_lat: got %0d expected 1", lat); end
        send(0, 32'h1003, 1'b0, 2'b11, 32'h0, lat, rd, ex);
        n_cmp++; if (ex !== 2'b11) begin n_bad++; $display("FAIL prio_excpt: got %b expected 11", ex); end
        send(0, 32'h1001, 1'b0, 2'b01, 32'h0, lat, rd, ex);
        n_cmp++; if (ex !== 2'b01) begin n_bad++; $display("FAIL prio_mis: got %b expected 01", ex); end
        send(0, 32'h0, 1'b1, 2'b10, 32'hCAFEF00D, lat, rd, ex);
        send(0, 32'h1000, 1'b1, 2'b10, 32'h0BADBEEF, lat, rd, ex);
        n_cmp++; if (ex !== 2'b10) begin n_bad++; $display("FAIL oor_excpt: got %b expected 10", ex); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL oor_lat: got %0d expected 1", lat); end
        send(0, 32'h0, 1'b0, 2'b10, 32'h0, lat, rd, ex);
        n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL oor_word0: got %h expected cafef00d", rd); end
    endtask

    task automatic test_handshake();
        int ht0, ht1, rt0, rt1, nresp, n;
        logic [31:0] rdv, rdv1;
        logic [1:0] exv;
        bit got2;
        ht0 = -100; ht1 = -100; rt0 = -1; rt1 = -1; nresp = 0; got2 = 1'b0;
        rdv = 32'h0; rdv1 = 32'h0; exv = 2'b00;
        @(negedge clk);
        req_addr = 32'h10; req_write = 1'b0; req_size = 2'b10; req_wdata = 32'h0; req_valid = 1'b1;
        n = 0;
        while (!rdy0 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        ht0 = cyc;
        for (int t = 0; t < 12 && !got2; t++) begin
            @(negedge clk);
            if (v0) begin
                nresp++;
                if (rt0 < 0) begin rt0 = cyc; rdv = rd0; exv = ex0; end
            end
            if (rdy0) begin
                req_addr = 32'h12; req_size = 2'b01; req_write = 1'b0;
                @(posedge clk);
                #1;
                ht1 = cyc; got2 = 1'b1; req_valid = 1'b0;
            end else begin
                req_addr = 32'h104 + 32'(t) * 4; req_size = 2'b11; req_write = 1'b1;
                req_wdata = 32'h55555555;
            end
        end
        for (int t = 0; t < 12 && rt1 < 0; t++) begin
            @(negedge clk);
            if (v0) begin rt1 = cyc; rdv1 = rd0; end
        end
        $display("txn dut=2 held-valid: hs0=%0d resp0=%0d rdata=%h hs1=%0d resp1=%0d rdata=%h",
                 ht0, rt0, rdv, ht1, rt1, rdv1);
        n_cmp++; if (rt0 - ht0 !== 3) begin n_bad++; $display("FAIL hold_lat: got %0d expected 3", rt0 - ht0); end
        n_cmp++; if (rdv !== 32'hAAADBEEF) begin n_bad++; $display("FAIL hold_rdata: got %h expected aaadbeef", rdv); end
        n_cmp++; if (exv !== 2'b00) begin n_bad++; $display("FAIL hold_excpt: got %b expected 00", exv); end
        n_cmp++; if (nresp !== 1) begin n_bad++; $display("FAIL hold_nresp: got %0d expected 1", nresp); end
        n_cmp++; if (ht1 - ht0 !== 4) begin n_bad++; $display("FAIL hold_next_acc: got %0d expected 4", ht1 - ht0); end
        n_cmp++; if (rdv1 !== 32'h0000AAAD) begin n_bad++; $display("FAIL hold_second: got %h expected 0000aaad", rdv1); end
    endtask

    task automatic test_reset_busy();
        int lat, n, nresp; logic [31:0] rd; logic [1:0] ex;
        send(0, 32'h20, 1'b1, 2'b10, 32'h11112222, lat, rd, ex);
        @(negedge clk);
        req_addr = 32'h20; req_write = 1'b1; req_size = 2'b10; req_wdata = 32'h12345678; req_valid = 1'b1;
        n = 0;
        while (!rdy0 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL rbusy_ready_in_rst: got %b expected 0", rdy0); end
        nresp = v0 ? 1 : 0;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL rbusy_ready: got %b expected 1", rdy0); end
        for (int t = 0; t < 6; t++) begin
            if (v0) nresp++;
            @(negedge clk);
        end
        $display("txn dut=2 store aborted by reset: responses=%0d", nresp);
        n_cmp++; if (nresp !== 0) begin n_bad++; $display("FAIL rbusy_noresp: got %0d expected 0", nresp); end
        send(0, 32'h20, 1'b0, 2'b10, 32'h0, lat, rd, ex);
        n_cmp++; if (rd !== 32'h11112222) begin n_bad++; $display("FAIL rbusy_old: got %h expected 11112222", rd); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rbusy_lat: got %0d expected 3", lat); end
    endtask

    task automatic test_back_to_back();
        int lat, ni, nr;
        logic [31:0] rd; logic [1:0] ex;
        logic [31:0] addrs [3];
        logic [31:0] exp_d [3];
        int ht [3];
        int rt [3];
        logic [31:0] rdat [3];
        addrs = '{32'h40, 32'h44, 32'h48};
        exp_d = '{32'h11111111, 32'h22222222, 32'h33333333};
        ht = '{-100, -100, -100};
        rt = '{-1, -1, -1};
        rdat = '{32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 3; i++) begin
            send(1, addrs[i], 1'b1, 2'b10, exp_d[i], lat, rd, ex);
            n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL w0_st_lat%0d: got %0d expected 1", i, lat); end
        end
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_addr = addrs[0]; req_valid = 1'b1;
        ni = 0; nr = 0;
        for (int t = 0; t < 30 && nr < 3; t++) begin
            if (v1 && nr < 3) begin rt[nr] = cyc; rdat[nr] = rd1; nr++; end
            if (rdy1 && ni < 3) begin
                @(posedge clk);
                #1;
                ht[ni] = cyc;
                ni++;
                if (ni < 3) req_addr = addrs[ni];
                else req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            $display("txn dut=0 load addr=%h hs=%0d resp=%0d rdata=%h", addrs[i], ht[i], rt[i], rdat[i]);
            n_cmp++; if (rt[i] - ht[i] !== 1) begin n_bad++; $display("FAIL w0_lat%0d: got %0d expected 1", i, rt[i] - ht[i]); end
            n_cmp++; if (rdat[i] !== exp_d[i]) begin n_bad++; $display("FAIL w0_rdata%0d: got %h expected %h", i, rdat[i], exp_d[i]); end
        end
        for (int i = 1; i < 3; i++) begin
            n_cmp++; if (ht[i] - ht[i-1] !== 2) begin n_bad++; $display("FAIL w0_gap%0d: got %0d expected 2", i, ht[i] - ht[i-1]); end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_exceptions();
        test_handshake();
        test_reset_busy();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
